// File: rtl/snn_pkg.sv
// Shared SNN datapath constants, used by the spike buffer, the weight SRAM
// wrapper and the synaptic accumulator.
package snn_pkg;

   localparam int N_PRE  = 24;   // spike bits (synapses) per row
   localparam int N_ROW  = 24;   // rows per post neuron
   localparam int N_NRN  = 18;   // post neurons per frame
   localparam int W_W    = 8;    // signed weight width
   localparam int ACC_W  = 18;   // signed accumulator / current width
   localparam int ADDR_W = 9;    // weight SRAM address width
   localparam int CNT_W  = 5;    // row / neuron counter width
   localparam int NRN_W  = 5;    // neuron index width on the output

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic [N_PRE*W_W-1:0]    w_row_t;

   // Sign-extend one weight to the accumulator width.
   function automatic acc_t sext_w(input logic [W_W-1:0] w);
      return acc_t'({{(ACC_W-W_W){w[W_W-1]}}, w});
   endfunction

endpackage

// File: rtl/syn_accum_if.sv
// Spike-row input, weight SRAM read port and current output of syn_accum.
interface syn_accum_if;
   import snn_pkg::*;

   logic                    i_clear;
   logic [N_PRE-1:0]        i_spike_bundle;
   logic                    i_valid;
   logic                    o_w_rd_en;
   logic [ADDR_W-1:0]       o_w_addr;
   w_row_t                  i_w_data;
   logic [ACC_W-1:0]        o_current;
   logic                    o_cur_valid;
   logic [NRN_W-1:0]        o_nrn_idx;
   logic                    o_done;

   // Upstream / SRAM / neuron-update side.
   modport master (
      output i_clear, i_spike_bundle, i_valid, i_w_data,
      input  o_w_rd_en, o_w_addr, o_current, o_cur_valid, o_nrn_idx, o_done
   );

   // Accumulator side.
   modport slave (
      input  i_clear, i_spike_bundle, i_valid, i_w_data,
      output o_w_rd_en, o_w_addr, o_current, o_cur_valid, o_nrn_idx, o_done
   );

endinterface

// File: rtl/syn_row_sum.sv
// Masked signed adder tree: sums the weights of one row whose spike bit is set.
// The result is registered; an idle cycle registers zero.
module syn_row_sum
   import snn_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             en,
   input  logic [N_PRE-1:0] spike,
   input  w_row_t           w_row,
   output acc_t             sum_q
);

   acc_t sum_d;

   // Sum of sign-extended weights gated by their spike bits.
   always_comb begin
      sum_d = '0;
      for (int k = 0; k < N_PRE; k++) begin
         if (spike[k]) begin
            sum_d = sum_d + sext_w(w_row[k*W_W +: W_W]);
         end
      end
   end

   // Register the row sum.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q <= '0;
      end else if (clear) begin
         sum_q <= '0;
      end else begin
         sum_q <= en ? sum_d : '0;
      end
   end

endmodule

// File: rtl/syn_accum.sv
// Synaptic accumulator: walks the spike rows of a frame, reads the matching
// weight rows, and accumulates 24 masked row sums into one signed current per
// post neuron. Row/neuron tags ride the pipeline so neurons can follow each
// other (and a new frame can start) while the previous neuron still drains.
module syn_accum
   import snn_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   syn_accum_if.slave  bus
);

   logic [CNT_W-1:0]  row_cnt;
   logic [CNT_W-1:0]  nrn_cnt;
   logic              row_last;
   logic              nrn_last;

   logic              s1_valid;
   logic [N_PRE-1:0]  s1_spike;
   logic              s1_first;
   logic              s1_last;
   logic [NRN_W-1:0]  s1_nrn;

   logic              s2_valid;
   logic              s2_first;
   logic              s2_last;
   logic [NRN_W-1:0]  s2_nrn;
   acc_t              sum_q;

   acc_t              acc;
   acc_t              acc_next;
   acc_t              cur_q;
   logic              cur_valid_q;
   logic [NRN_W-1:0]  nrn_idx_q;
   logic              done_q;

   assign row_last = (row_cnt == CNT_W'(N_ROW-1));
   assign nrn_last = (nrn_cnt == CNT_W'(N_NRN-1));

   // Row and neuron counters, stepped only by accepted spike rows.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_cnt <= '0;
         nrn_cnt <= '0;
      end else if (bus.i_clear) begin
         row_cnt <= '0;
         nrn_cnt <= '0;
      end else if (bus.i_valid) begin
         if (row_last) begin
            row_cnt <= '0;
            nrn_cnt <= nrn_last ? '0 : nrn_cnt + CNT_W'(1);
         end else begin
            row_cnt <= row_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.o_w_rd_en = bus.i_valid & ~bus.i_clear;
   assign bus.o_w_addr  = ADDR_W'(nrn_cnt) * ADDR_W'(N_ROW) + ADDR_W'(row_cnt);

   // Stage 1: spikes and tags, aligned with the weight row returned by the SRAM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_spike <= '0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_nrn   <= '0;
      end else if (bus.i_clear) begin
         s1_valid <= 1'b0;
         s1_spike <= '0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_nrn   <= '0;
      end else begin
         s1_valid <= bus.i_valid;
         s1_spike <= bus.i_spike_bundle;
         s1_first <= (row_cnt == '0);
         s1_last  <= row_last;
         s1_nrn   <= NRN_W'(nrn_cnt);
      end
   end

   syn_row_sum u_row_sum (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (bus.i_clear),
      .en      (s1_valid),
      .spike   (s1_spike),
      .w_row   (bus.i_w_data),
      .sum_q   (sum_q)
   );

   // Stage 2: tags follow the registered row sum.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid <= 1'b0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
         s2_nrn   <= '0;
      end else if (bus.i_clear) begin
         s2_valid <= 1'b0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
         s2_nrn   <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_first <= s1_first;
         s2_last  <= s1_last;
         s2_nrn   <= s1_nrn;
      end
   end

   // First row restarts the sum so the previous neuron leaves no residue.
   always_comb begin
      acc_next = (s2_first ? acc_t'(0) : acc) + sum_q;
   end

   // Stage 3: accumulate and publish the finished current on the last row.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc         <= '0;
         cur_q       <= '0;
         cur_valid_q <= 1'b0;
         nrn_idx_q   <= '0;
         done_q      <= 1'b0;
      end else if (bus.i_clear) begin
         acc         <= '0;
         cur_q       <= '0;
         cur_valid_q <= 1'b0;
         nrn_idx_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         cur_valid_q <= 1'b0;
         done_q      <= 1'b0;
         if (s2_valid) begin
            acc <= acc_next;
            if (s2_last) begin
               cur_q       <= acc_next;
               cur_valid_q <= 1'b1;
               nrn_idx_q   <= s2_nrn;
               done_q      <= (s2_nrn == NRN_W'(N_NRN-1));
            end
         end
      end
   end

   assign bus.o_current   = cur_q;
   assign bus.o_cur_valid = cur_valid_q;
   assign bus.o_nrn_idx   = nrn_idx_q;
   assign bus.o_done      = done_q;

endmodule
